ps2_frame_rx: RTL

- Upstream stage of the keyboard path: receives raw PS/2 device-to-host frames on ps2_clk/ps2_data and emits validated scan codes to the scan-code-to-ASCII stage in text_IO.
- Synchronises and de-glitches the PS/2 lines, checks each 11-bit frame (start, 8 data LSB-first, odd parity, stop), tracks the E0/F0 prefixes, and aborts stalled frames on a timeout.
- Delivers one single-cycle pulse per completed key event.

---
 rtl/ps2_pkg.sv | 22 ++
 rtl/ps2_line_filter.sv | 39 +++
 rtl/ps2_frame_rx.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/ps2_pkg.sv
// Shared types, byte constants and timeout sizing for the PS/2 receive path.
package ps2_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } ps2_state_t;

  localparam logic [7:0] PS2_EXT = 8'hE0;
  localparam logic [7:0] PS2_BRK = 8'hF0;

  function automatic int ps2_timeout_cyc(input int clk_hz, input int timeout_us);
    return (clk_hz / 1_000_000) * timeout_us;
  endfunction

  function automatic int ps2_timeout_width(input int clk_hz, input int timeout_us);
    return $clog2(ps2_timeout_cyc(clk_hz, timeout_us) + 1);
  endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// Synchronises and debounces one PS/2 line and strobes its filtered falling edge.
module ps2_line_filter #(
  parameter int FILTER_LEN = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic line_in,
  output logic fe
);
  localparam int CW = $clog2(FILTER_LEN + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(FILTER_LEN - 1);

  logic [1:0]    sync_reg;
  logic          level_reg;
  logic [CW-1:0] cnt_reg;

  // Sync chain and filter preset high so the idle bus never looks like an edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_reg  <= 2'b11;
      level_reg <= 1'b1;
      cnt_reg   <= '0;
      fe        <= 1'b0;
    end else begin
      sync_reg <= {sync_reg[0], line_in};
      fe       <= 1'b0;
      if (sync_reg[1] == level_reg) begin
        cnt_reg <= '0;
      end else if (cnt_reg == CNT_LAST) begin
        level_reg <= sync_reg[1];
        cnt_reg   <= '0;
        fe        <= level_reg;
      end else begin
        cnt_reg <= cnt_reg + 1'b1;
      end
    end
  end

endmodule

// File: rtl/ps2_frame_rx.sv
// PS/2 device-to-host frame receiver: 11-bit frame check, timeout abort, scan-code pulse.
// Define PS2_PREFIX_DECODE_EN to fold E0/F0 prefixes into is_extended/is_break.
module ps2_frame_rx
  import ps2_pkg::*;
#(
  parameter int CLK_HZ     = 100_000_000,
  parameter int TIMEOUT_US = 200,
  parameter int FILTER_LEN = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] code_out,
  output logic       code_valid,
  output logic       is_break,
  output logic       is_extended,
  output logic       frame_err,
  output logic       busy
);
  localparam int TIMEOUT_CYC = ps2_timeout_cyc(CLK_HZ, TIMEOUT_US);
  localparam int TO_W        = ps2_timeout_width(CLK_HZ, TIMEOUT_US);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);

  logic            fe;
  logic [1:0]      data_sync_reg;
  logic            data_s;
  ps2_state_t      state_reg;
  logic [2:0]      bit_cnt_reg;
  logic [7:0]      byte_reg;
  logic            parity_reg;
  logic [TO_W-1:0] to_cnt_reg;
  logic            timeout;
  logic            frame_ok;

`ifdef PS2_PREFIX_DECODE_EN
  logic ext_flag_reg;
  logic brk_flag_reg;
`else
  assign is_break    = 1'b0;
  assign is_extended = 1'b0;
`endif

  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filter (
    .clk     (clk),
    .reset   (reset),
    .line_in (ps2_clk),
    .fe      (fe)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) data_sync_reg <= 2'b11;
    else        data_sync_reg <= {data_sync_reg[0], ps2_data};
  end

  assign data_s   = data_sync_reg[1];
  assign busy     = (state_reg != IDLE);
  // An edge arriving on the expiry cycle keeps the frame alive.
  assign timeout  = (state_reg != IDLE) && !fe && (to_cnt_reg == TO_LAST);
  assign frame_ok = (^byte_reg ^ parity_reg) & data_s;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg   <= IDLE;
      bit_cnt_reg <= '0;
      byte_reg    <= '0;
      parity_reg  <= 1'b0;
      to_cnt_reg  <= '0;
      code_out    <= '0;
      code_valid  <= 1'b0;
      frame_err   <= 1'b0;
`ifdef PS2_PREFIX_DECODE_EN
      is_break     <= 1'b0;
      is_extended  <= 1'b0;
      ext_flag_reg <= 1'b0;
      brk_flag_reg <= 1'b0;
`endif
    end else begin
      code_valid <= 1'b0;
      frame_err  <= 1'b0;
      to_cnt_reg <= (state_reg == IDLE || fe || timeout) ? '0 : to_cnt_reg + 1'b1;
      if (timeout) begin
        state_reg <= IDLE;
        frame_err <= 1'b1;
`ifdef PS2_PREFIX_DECODE_EN
        ext_flag_reg <= 1'b0;
        brk_flag_reg <= 1'b0;
`endif
      end else if (fe) begin
        case (state_reg)
          IDLE: begin
            // A high data line at a clock edge is a spurious start; ignore it.
            if (!data_s) begin
              state_reg   <= DATA;
              bit_cnt_reg <= '0;
            end
          end
          DATA: begin
            byte_reg[bit_cnt_reg] <= data_s;
            bit_cnt_reg           <= bit_cnt_reg + 1'b1;
            if (bit_cnt_reg == 3'd7) state_reg <= PARITY;
          end
          PARITY: begin
            parity_reg <= data_s;
            state_reg  <= STOP;
          end
          STOP: begin
            state_reg <= IDLE;
`ifdef PS2_PREFIX_DECODE_EN
            if (!frame_ok) begin
              frame_err    <= 1'b1;
              ext_flag_reg <= 1'b0;
              brk_flag_reg <= 1'b0;
            end else if (byte_reg == PS2_EXT) begin
              ext_flag_reg <= 1'b1;
            end else if (byte_reg == PS2_BRK) begin
              brk_flag_reg <= 1'b1;
            end else begin
              code_out     <= byte_reg;
              is_break     <= brk_flag_reg;
              is_extended  <= ext_flag_reg;
              code_valid   <= 1'b1;
              ext_flag_reg <= 1'b0;
              brk_flag_reg <= 1'b0;
            end
`else
            if (!frame_ok) begin
              frame_err <= 1'b1;
            end else begin
              code_out   <= byte_reg;
              code_valid <= 1'b1;
            end
`endif
          end
          default: state_reg <= IDLE;
        endcase
      end
    end
  end

endmodule
